// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, instruction-memory request and a 2-entry
// return FIFO presenting {instr, pc} to decode over valid/ready.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   imem_en, imem_addr  - read strobe and fetch address (= pc when issuing)
//   imem_rdata          - read data, valid the cycle after imem_en
//   if_valid, if_ready  - decode handshake on the FIFO head
//   if_instr, if_pc     - instruction at FIFO head and its address
//   change_pc, br_target- taken-branch redirect from execute

module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               change_pc,
    input  logic [ADDR_W-1:0]  br_target
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q [2];
    logic [INSTR_W-1:0] instr_d [2];
    logic [ADDR_W-1:0]  epc_q [2];
    logic [ADDR_W-1:0]  epc_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               squash_q, squash_d;

    logic               valid;
    logic               pop;
    logic               push;
    logic               issue;
    logic [2:0]         occ;

    // Handshake and issue decision.
    always_comb begin
        // A redirect hides the head so nothing from the old path is consumed.
        valid = (count_q != 2'd0) & ~change_pc;
        pop   = valid & if_ready;
        // Returning data is dropped if it was squashed or a redirect lands now.
        push  = inflight_q & ~squash_q & ~change_pc;
        // Slots promised after this edge: entries plus data still to return.
        occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = ~rst & (occ < 3'd2);
    end

    assign imem_en   = issue;
    assign imem_addr = pc_q;
    assign if_valid  = valid;
    assign if_instr  = instr_q[rd_ptr_q];
    assign if_pc     = epc_q[rd_ptr_q];

    // Next-state logic.
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        epc_d         = epc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        inflight_d    = issue;
        inflight_pc_d = pc_q;
        // A fetch issued alongside a redirect belongs to the old path.
        squash_d      = change_pc & issue;

        if (push) begin
            instr_d[wr_ptr_q] = imem_rdata;
            epc_d[wr_ptr_q]   = inflight_pc_q;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        if (change_pc) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            pc_d     = br_target;
        end else if (issue) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= PC_RESET;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                epc_q[i]   <= '0;
            end
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            squash_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            epc_q         <= epc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            squash_q      <= squash_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit with a word=addr
// synchronous memory model; second instance covers PC wrap-around.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        change_pc = 1'b0;
    logic [31:0] br_target = '0;

    logic        w_imem_en;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata = '0;
    logic        w_if_valid;
    logic        w_if_ready = 1'b1;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;
    logic        w_change_pc = 1'b0;
    logic [31:0] w_br_target = '0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_en) imem_rdata <= imem_addr;
    always @(posedge clk) if (w_imem_en) w_imem_rdata <= w_imem_addr;

    fetch_unit u_dut (
        .clk(clk), .rst(rst),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc),
        .change_pc(change_pc), .br_target(br_target)
    );

    fetch_unit #(.PC_RESET(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .if_valid(w_if_valid), .if_ready(w_if_ready),
        .if_instr(w_if_instr), .if_pc(w_if_pc),
        .change_pc(w_change_pc), .br_target(w_br_target)
    );

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        change_pc = 1'b0;
        br_target = '0;
        if_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        change_pc = 1'b1;
        br_target = 32'h200;
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b0 || if_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl en=%0b valid=%0b want 0/0", imem_en, if_valid);
        end
        checks++;
        if (if_instr !== 32'h0 || if_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_data instr=%h pc=%h want 0/0", if_instr, if_pc);
        end
        checks++;
        if (w_imem_en !== 1'b0 || w_if_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_wrap en=%0b valid=%0b want 0/0", w_imem_en, w_if_valid);
        end
        @(posedge clk); #1;
        change_pc = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_first en=%0b addr=%h want 1/0", imem_en, imem_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int e_addr [8] = '{0, 4, 8, 12, 16, 20, 24, 28};
        int e_v    [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
        int e_pc   [8] = '{0, 0, 0, 4, 8, 12, 16, 20};
        do_reset();
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            checks++;
            if (imem_en !== 1'b1 || imem_addr !== 32'(e_addr[n])) begin
                fails++;
                $display("FAIL stream_issue c%0d en=%0b addr=%h want 1/%h",
                         n, imem_en, imem_addr, e_addr[n]);
            end
            checks++;
            if (if_valid !== 1'(e_v[n])) begin
                fails++;
                $display("FAIL stream_valid c%0d got %0b want %0d", n, if_valid, e_v[n]);
            end
            if (e_v[n] == 1) begin
                checks++;
                if (if_pc !== 32'(e_pc[n]) || if_instr !== 32'(e_pc[n])) begin
                    fails++;
                    $display("FAIL stream_data c%0d pc=%h instr=%h want %h",
                             n, if_pc, if_instr, e_pc[n]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int rdy    [13] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        int e_en   [13] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        int e_addr [13] = '{0, 4, 8, 12, 16, 0, 0, 0, 0, 20, 24, 28, 32};
        int e_v    [13] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        int e_pc   [13] = '{0, 0, 0, 4, 8, 12, 12, 12, 12, 12, 16, 20, 24};
        do_reset();
        for (int n = 0; n < 13; n++) begin
            if_ready = 1'(rdy[n]);
            @(negedge clk);
            checks++;
            if (imem_en !== 1'(e_en[n])) begin
                fails++;
                $display("FAIL bp_en c%0d got %0b want %0d", n, imem_en, e_en[n]);
            end
            if (e_en[n] == 1) begin
                checks++;
                if (imem_addr !== 32'(e_addr[n])) begin
                    fails++;
                    $display("FAIL bp_addr c%0d got %h want %h", n, imem_addr, e_addr[n]);
                end
            end
            checks++;
            if (if_valid !== 1'(e_v[n])) begin
                fails++;
                $display("FAIL bp_valid c%0d got %0b want %0d", n, if_valid, e_v[n]);
            end
            if (e_v[n] == 1) begin
                checks++;
                if (if_pc !== 32'(e_pc[n]) || if_instr !== 32'(e_pc[n])) begin
                    fails++;
                    $display("FAIL bp_data c%0d pc=%h instr=%h want %h",
                             n, if_pc, if_instr, e_pc[n]);
                end
            end
            @(posedge clk); #1;
        end
        if_ready = 1'b1;
    endtask

    // Redirect while the FIFO holds a word and another is in flight.
    task automatic test_redirect();
        int chg    [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        int e_en   [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
        int e_addr [8] = '{0, 4, 0, 'h100, 'h104, 'h108, 'h10C, 'h110};
        int e_v    [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        int e_pc   [8] = '{0, 0, 0, 0, 0, 'h100, 'h104, 'h108};
        do_reset();
        for (int n = 0; n < 8; n++) begin
            change_pc = 1'(chg[n]);
            br_target = 32'h100;
            @(negedge clk);
            checks++;
            if (imem_en !== 1'(e_en[n])) begin
                fails++;
                $display("FAIL redir_en c%0d got %0b want %0d", n, imem_en, e_en[n]);
            end
            if (e_en[n] == 1) begin
                checks++;
                if (imem_addr !== 32'(e_addr[n])) begin
                    fails++;
                    $display("FAIL redir_addr c%0d got %h want %h", n, imem_addr, e_addr[n]);
                end
            end
            checks++;
            if (if_valid !== 1'(e_v[n])) begin
                fails++;
                $display("FAIL redir_valid c%0d got %0b want %0d pc=%h",
                         n, if_valid, e_v[n], if_pc);
            end
            if (e_v[n] == 1) begin
                checks++;
                if (if_pc !== 32'(e_pc[n]) || if_instr !== 32'(e_pc[n])) begin
                    fails++;
                    $display("FAIL redir_data c%0d pc=%h instr=%h want %h",
                             n, if_pc, if_instr, e_pc[n]);
                end
            end
            @(posedge clk); #1;
        end
        change_pc = 1'b0;
    endtask

    // Redirect while a fetch issues in the same cycle: it must be squashed.
    task automatic test_squash();
        int chg    [6] = '{0, 1, 0, 0, 0, 0};
        int e_addr [6] = '{0, 4, 'h100, 'h104, 'h108, 'h10C};
        int e_v    [6] = '{0, 0, 0, 0, 1, 1};
        int e_pc   [6] = '{0, 0, 0, 0, 'h100, 'h104};
        do_reset();
        for (int n = 0; n < 6; n++) begin
            change_pc = 1'(chg[n]);
            br_target = 32'h100;
            @(negedge clk);
            checks++;
            if (imem_en !== 1'b1 || imem_addr !== 32'(e_addr[n])) begin
                fails++;
                $display("FAIL squash_issue c%0d en=%0b addr=%h want 1/%h",
                         n, imem_en, imem_addr, e_addr[n]);
            end
            checks++;
            if (if_valid !== 1'(e_v[n])) begin
                fails++;
                $display("FAIL squash_valid c%0d got %0b want %0d pc=%h",
                         n, if_valid, e_v[n], if_pc);
            end
            if (e_v[n] == 1) begin
                checks++;
                if (if_pc !== 32'(e_pc[n]) || if_instr !== 32'(e_pc[n])) begin
                    fails++;
                    $display("FAIL squash_data c%0d pc=%h instr=%h want %h",
                             n, if_pc, if_instr, e_pc[n]);
                end
            end
            @(posedge clk); #1;
        end
        change_pc = 1'b0;
    endtask

    task automatic test_back_to_back();
        int chg    [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
        int tgt    [9] = '{0, 0, 0, 'h40, 'h80, 0, 0, 0, 0};
        int e_en   [9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
        int e_addr [9] = '{0, 4, 8, 0, 'h40, 'h80, 'h84, 'h88, 'h8C};
        int e_v    [9] = '{0, 0, 1, 0, 0, 0, 0, 1, 1};
        int e_pc   [9] = '{0, 0, 0, 0, 0, 0, 0, 'h80, 'h84};
        do_reset();
        for (int n = 0; n < 9; n++) begin
            change_pc = 1'(chg[n]);
            br_target = 32'(tgt[n]);
            @(negedge clk);
            checks++;
            if (imem_en !== 1'(e_en[n])) begin
                fails++;
                $display("FAIL b2b_en c%0d got %0b want %0d", n, imem_en, e_en[n]);
            end
            if (e_en[n] == 1) begin
                checks++;
                if (imem_addr !== 32'(e_addr[n])) begin
                    fails++;
                    $display("FAIL b2b_addr c%0d got %h want %h", n, imem_addr, e_addr[n]);
                end
            end
            checks++;
            if (if_valid !== 1'(e_v[n])) begin
                fails++;
                $display("FAIL b2b_valid c%0d got %0b want %0d pc=%h",
                         n, if_valid, e_v[n], if_pc);
            end
            if (e_v[n] == 1) begin
                checks++;
                if (if_pc !== 32'(e_pc[n]) || if_instr !== 32'(e_pc[n])) begin
                    fails++;
                    $display("FAIL b2b_data c%0d pc=%h instr=%h want %h",
                             n, if_pc, if_instr, e_pc[n]);
                end
            end
            @(posedge clk); #1;
        end
        change_pc = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] e_addr [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        logic [31:0] e_pc   [5] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        int          e_v    [5] = '{0, 0, 1, 1, 1};
        do_reset();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if (w_imem_en !== 1'b1 || w_imem_addr !== e_addr[n]) begin
                fails++;
                $display("FAIL wrap_issue c%0d en=%0b addr=%h want 1/%h",
                         n, w_imem_en, w_imem_addr, e_addr[n]);
            end
            checks++;
            if (w_if_valid !== 1'(e_v[n])) begin
                fails++;
                $display("FAIL wrap_valid c%0d got %0b want %0d", n, w_if_valid, e_v[n]);
            end
            if (e_v[n] == 1) begin
                checks++;
                if (w_if_pc !== e_pc[n] || w_if_instr !== e_pc[n]) begin
                    fails++;
                    $display("FAIL wrap_data c%0d pc=%h instr=%h want %h",
                             n, w_if_pc, w_if_instr, e_pc[n]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (4) begin
            @(posedge clk); #1;
        end
        // Cycle 4: fetch of 12 was issued last cycle; its data is now due.
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || imem_en !== 1'b0 || if_pc !== 32'h0) begin
            fails++;
            $display("FAIL midrst_hold valid=%0b en=%0b pc=%h want 0/0/0",
                     if_valid, imem_en, if_pc);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL midrst_issue en=%0b addr=%h want 1/0", imem_en, imem_addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h4) begin
            fails++;
            $display("FAIL midrst_stale valid=%0b pc=%h addr=%h want 0/-/4",
                     if_valid, if_pc, imem_addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            fails++;
            $display("FAIL midrst_first valid=%0b pc=%h instr=%h want 1/0/0",
                     if_valid, if_pc, if_instr);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_squash();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
